// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_pkg
//  Description : Shared types and helper functions for the SECDED decoder
//                family (parity-width sizing, codeword sizing, data-bit
//                extraction from an extended Hamming codeword).
//  Revision    : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    // Upper bound on codeword width handled by the extraction helper.
    localparam int MAX_CODE_W    = 128;
    // Storage width of the error position inside the status struct.
    localparam int ERR_POS_MAX_W = 8;

    typedef struct packed {
        logic                     sec;
        logic                     ded;
        logic [ERR_POS_MAX_W-1:0] err_pos;
    } status_t;

    // Smallest P such that 2^P >= data_w + P + 1.
    function automatic int calc_parity_w(input int data_w);
        int p;
        p = 0;
        for (int k = 1; k < 31; k++) begin
            if (p == 0 && (1 << k) >= data_w + k + 1) begin
                p = k;
            end
        end
        return p;
    endfunction

    // Full codeword width including the overall-parity bit.
    function automatic int codeword_w(input int data_w);
        return data_w + calc_parity_w(data_w) + 1;
    endfunction

    // Gathers the data bits (non power-of-two Hamming positions) in ascending
    // order; index i holds Hamming position i+1, the top index is overall parity.
    function automatic logic [MAX_CODE_W-1:0] extract_data(
        input logic [MAX_CODE_W-1:0] code,
        input int                    code_w
    );
        logic [MAX_CODE_W-1:0] d;
        int                    j;
        d = '0;
        j = 0;
        for (int i = 0; i < MAX_CODE_W - 1; i++) begin
            if (i < code_w - 1 && ((i + 1) & i) != 0) begin
                d[j] = code[i];
                j++;
            end
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_syndrome_calc.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_syndrome_calc
//  Description : Combinational syndrome and overall-parity generator for an
//                extended Hamming codeword. Shared by decoder and scrubber.
//  Revision    : 1.0 - initial release
// ============================================================================
module hamming_syndrome_calc #(
    parameter int N = 8,
    parameter int P = 3
) (
    input  logic [N-1:0] i_code,
    output logic [P-1:0] o_syndrome,
    output logic         o_parity
);

    // Syndrome bit k is the XOR of all positions whose number has bit k set.
    always_comb begin
        o_syndrome = '0;
        for (int i = 0; i < N - 1; i++) begin
            for (int k = 0; k < P; k++) begin
                if ((((i + 1) >> k) & 1) == 1) begin
                    o_syndrome[k] = o_syndrome[k] ^ i_code[i];
                end
            end
        end
        o_parity = ^i_code;
    end

endmodule
`default_nettype wire

// File: rtl/hamming_secded_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_secded_pipe
//  Description : Two-stage pipelined SECDED (extended Hamming) decoder with
//                valid/ready streaming, per-word error injection and
//                saturating corrected/uncorrectable statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module hamming_secded_pipe
    import hamming_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [codeword_w(DATA_W)-1:0]          in_code,
    input  logic [codeword_w(DATA_W)-1:0]          in_inj_mask,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DATA_W-1:0]                      out_data,
    output logic                                   out_sec,
    output logic                                   out_ded,
    output logic [$clog2(codeword_w(DATA_W))-1:0]  out_err_pos,
    output logic [calc_parity_w(DATA_W)-1:0]       out_syndrome,
    input  logic                                   stat_clr,
    output logic [CNT_W-1:0]                       sec_count,
    output logic [CNT_W-1:0]                       ded_count
);

    localparam int P     = calc_parity_w(DATA_W);
    localparam int N     = codeword_w(DATA_W);
    localparam int POS_W = $clog2(N);

    // Pipeline registers
    logic                  r_s1_valid;
    logic [N-1:0]          r_s1_code;
    logic [P-1:0]          r_s1_syn;
    logic                  r_s1_par;
    logic                  r_s2_valid;
    logic [DATA_W-1:0]     r_s2_data;
    status_t               r_s2_status;
    logic [P-1:0]          r_s2_syn;
    logic [CNT_W-1:0]      r_sec_cnt;
    logic [CNT_W-1:0]      r_ded_cnt;

    // Combinational nets
    logic                  w_advance;
    logic                  w_out_fire;
    logic [N-1:0]          w_masked;
    logic [P-1:0]          w_syn;
    logic                  w_par;
    logic [N-1:0]          w_corr;
    status_t               w_status;
    logic [MAX_CODE_W-1:0] w_corr_pad;
    logic [MAX_CODE_W-1:0] w_ext;
    logic                  w_unused_bits;

    assign w_advance  = !r_s2_valid || out_ready;
    assign w_out_fire = r_s2_valid && out_ready;
    assign w_masked   = in_code ^ in_inj_mask;

    hamming_syndrome_calc #(
        .N (N),
        .P (P)
    ) u_syn (
        .i_code     (w_masked),
        .o_syndrome (w_syn),
        .o_parity   (w_par)
    );

    // Stage 1: capture the injected codeword together with its syndrome/parity.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
            r_s1_syn   <= '0;
            r_s1_par   <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            r_s1_code  <= w_masked;
            r_s1_syn   <= w_syn;
            r_s1_par   <= w_par;
        end
    end

    // Classify the error pattern and flip the faulty bit when it is correctable.
    always_comb begin
        w_corr   = r_s1_code;
        w_status = '0;
        if (r_s1_syn == '0) begin
            if (r_s1_par) begin
                // Only the overall-parity bit is wrong; payload is intact.
                w_status.sec     = 1'b1;
                w_status.err_pos = ERR_POS_MAX_W'(N - 1);
            end
        end else if (!r_s1_par) begin
            w_status.ded = 1'b1;
        end else if (int'(r_s1_syn) <= N - 1) begin
            w_status.sec     = 1'b1;
            w_status.err_pos = ERR_POS_MAX_W'(int'(r_s1_syn) - 1);
            for (int i = 0; i < N - 1; i++) begin
                if (int'(r_s1_syn) == i + 1) begin
                    w_corr[i] = ~r_s1_code[i];
                end
            end
        end else begin
            // Syndrome points past the end of the codeword: cannot be a single error.
            w_status.ded = 1'b1;
        end
    end

    // Zero-extend the corrected word to the width the extraction helper expects.
    always_comb begin
        w_corr_pad         = '0;
        w_corr_pad[N-1:0]  = w_corr;
    end

    assign w_ext = extract_data(w_corr_pad, N);

    // Stage 2: register the decoded payload and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_data   <= '0;
            r_s2_status <= '0;
            r_s2_syn    <= '0;
        end else if (w_advance) begin
            r_s2_valid  <= r_s1_valid;
            r_s2_data   <= w_ext[DATA_W-1:0];
            r_s2_status <= w_status;
            r_s2_syn    <= r_s1_syn;
        end
    end

    // Saturating statistics, counted on the output handshake; clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else if (stat_clr) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else if (w_out_fire) begin
            if (r_s2_status.sec && r_sec_cnt != {CNT_W{1'b1}}) begin
                r_sec_cnt <= r_sec_cnt + CNT_W'(1);
            end
            if (r_s2_status.ded && r_ded_cnt != {CNT_W{1'b1}}) begin
                r_ded_cnt <= r_ded_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready     = w_advance;
    assign out_valid    = r_s2_valid;
    assign out_data     = r_s2_data;
    assign out_sec      = r_s2_status.sec;
    assign out_ded      = r_s2_status.ded;
    assign out_err_pos  = r_s2_status.err_pos[POS_W-1:0];
    assign out_syndrome = r_s2_syn;
    assign sec_count    = r_sec_cnt;
    assign ded_count    = r_ded_cnt;

    // Upper helper bits are structurally zero and intentionally dropped.
    assign w_unused_bits = ^{w_ext[MAX_CODE_W-1:DATA_W],
                             r_s2_status.err_pos[ERR_POS_MAX_W-1:POS_W]};

endmodule
`default_nettype wire
